serial_divider: RTL and testbench

SERIAL_DIVIDER -- requirements
Module: serial_divider

---
 rtl/serial_divider.sv | 172 +++++++++++++++++
 tb/tb_serial_divider.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// ---------------------------------------------------------------------------
// serial_divider
//   Unsigned restoring divider, one quotient bit per clock, MSB first.
//   Operands are taken with a valid/ready handshake, the result is offered
//   with a valid/ready handshake and held until consumed.
//
//   Ports
//     clk          : clock, all state changes on the rising edge
//     rst_n        : asynchronous active-low reset
//     in_valid     : dividend/divisor presented
//     in_ready     : divider idle and able to accept operands
//     dividend     : unsigned dividend  [WIDTH-1:0]
//     divisor      : unsigned divisor   [WIDTH-1:0]
//     out_valid    : result available
//     out_ready    : consumer takes the result
//     quotient     : unsigned quotient  [WIDTH-1:0]
//     remainder    : unsigned remainder [WIDTH-1:0]
//     div_by_zero  : result came from a zero divisor (zero-check build only)
//
//   Build option
//     SERIAL_DIVIDER_ZERO_CHECK_EN : when defined, a zero divisor is
//     recognised in the first cycle after acceptance and the result is
//     delivered after one cycle with div_by_zero = 1. When undefined, a zero
//     divisor runs the full WIDTH-step algorithm, which naturally yields
//     quotient = all ones and remainder = dividend; div_by_zero stays 0.
// ---------------------------------------------------------------------------
module serial_divider #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

`ifdef SERIAL_DIVIDER_ZERO_CHECK_EN
    localparam bit ZERO_CHECK_EN = 1'b1;
`else
    localparam bit ZERO_CHECK_EN = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend, shifted out MSB first
    logic [WIDTH-1:0] dvs_q, dvs_d;     // registered divisor
    logic [WIDTH-1:0] acc_q, acc_d;     // quotient being built
    logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder being built
    logic [WIDTH-1:0] quo_q, quo_d;     // published quotient
    logic [WIDTH-1:0] rem_q, rem_d;     // published remainder
    logic             dbz_q, dbz_d;

    // One restoring step. The partial remainder is one bit wider than the
    // operands so the compare sees the bit shifted out of prem_q. When the
    // subtraction happens the true difference is below the divisor and fits
    // in WIDTH bits, so a WIDTH-bit subtract is exact. For a zero divisor
    // the compare always succeeds and the remainder register simply fills
    // with the dividend bits, giving quotient all ones, remainder dividend.
    logic [WIDTH:0]   partial;
    logic             step_ge;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_acc;

    assign partial  = {prem_q, dvd_q[WIDTH-1]};
    assign step_ge  = (partial >= {1'b0, dvs_q});
    assign step_rem = step_ge ? (partial[WIDTH-1:0] - dvs_q) : partial[WIDTH-1:0];
    assign step_acc = (acc_q << 1) | {{(WIDTH-1){1'b0}}, step_ge};

    // Ready is also gated by rst_n so it reads 0 for the whole reset interval.
    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        acc_d   = acc_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    acc_d   = '0;
                    prem_d  = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CALC;
                end
            end

            CALC: begin
                if (ZERO_CHECK_EN && (dvs_q == '0)) begin
                    // The zero check takes the place of the first step; the
                    // dividend register has not been shifted yet.
                    quo_d   = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    dvd_d  = dvd_q << 1;
                    acc_d  = step_acc;
                    prem_d = step_rem;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        quo_d   = step_acc;
                        rem_d   = step_rem;
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            acc_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            acc_q   <= acc_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_serial_divider.sv
// ---------------------------------------------------------------------------
// tb_serial_divider
//   Self-checking bench for serial_divider: a WIDTH=20 instance exercised by
//   directed and random transactions against an arithmetic reference model,
//   plus a WIDTH=8 instance for a single narrow-width case.
//   Honours SERIAL_DIVIDER_ZERO_CHECK_EN for zero-divisor expectations.
// ---------------------------------------------------------------------------
module tb_serial_divider;

    localparam int W  = 20;
    localparam int W8 = 8;

`ifdef SERIAL_DIVIDER_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    logic          in_valid8;
    logic          in_ready8;
    logic [W8-1:0] dividend8;
    logic [W8-1:0] divisor8;
    logic          out_valid8;
    logic          out_ready8;
    logic [W8-1:0] quotient8;
    logic [W8-1:0] remainder8;
    logic          div_by_zero8;

    int checks = 0;
    int errors = 0;

    serial_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    serial_divider #(.WIDTH(W8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .quotient    (quotient8),
        .remainder   (remainder8),
        .div_by_zero (div_by_zero8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic, with the zero-divisor convention.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output int lat);
        if (b == '0) begin
            q   = '1;
            r   = a;
            dbz = ZC;
            lat = ZC ? 1 : W;
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
            lat = W;
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    // Issue one operation, measure latency, optionally stall the consumer
    // (optionally while waving junk operands), then consume the result.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall, input bit junk);
        logic [W-1:0] eq, er;
        logic         edbz;
        int           elat;
        int           lat;
        model(a, b, eq, er, edbz, elat);
        wait_ready();
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check("busy_in_ready", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, elat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edbz);
        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_quotient", quotient, eq);
            check("stall_remainder", remainder, er);
            check("stall_dbz", div_by_zero, edbz);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("consumed_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_quotient_hold", quotient, eq);
        $display("txn %0d / %0d -> q %0d r %0d dbz %0d lat %0d stall %0d",
                 a, b, quotient, remainder, div_by_zero, lat, stall);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int           lat8;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        dividend   = '0;
        divisor    = '0;
        out_ready  = 1'b0;
        in_valid8  = 1'b0;
        dividend8  = '0;
        divisor8   = '0;
        out_ready8 = 1'b0;

        // Reset state
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_in_ready8", in_ready8, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Directed cases
        run_txn(W'(100), W'(7), 0, 1'b0);
        run_txn(W'('hFFFFF), W'(1), 0, 1'b0);
        run_txn(W'(5), W'(9), 0, 1'b0);
        run_txn(W'('h12345), W'(0), 0, 1'b0);
        run_txn(W'('hFFFFF), W'('hFFFFF), 10, 1'b1);
        run_txn(W'(0), W'(5), 2, 1'b0);
        run_txn(W'(0), W'(0), 1, 1'b0);

        // Reset in the middle of CALC, around step 8
        wait_ready();
        in_valid = 1'b1;
        dividend = W'('h54321);
        divisor  = W'(3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("mid_calc_out_valid", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        $display("txn reset asserted during CALC of %0d / %0d", 'h54321, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerst_in_ready", in_ready, 1);
        run_txn(W'(1000), W'(10), 0, 1'b0);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
            run_txn(ra, rb, int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
        end

        // Narrow instance: 255 / 16
        in_valid8 = 1'b1;
        dividend8 = 8'd255;
        divisor8  = 8'd16;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat8 = 0;
        while (!out_valid8 && lat8 < 50) begin
            @(posedge clk); #1;
            lat8++;
        end
        check("w8_latency", lat8, 8);
        check("w8_quotient", quotient8, 15);
        check("w8_remainder", remainder8, 15);
        check("w8_dbz", div_by_zero8, 0);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check("w8_consumed", out_valid8, 0);
        $display("txn w8 255 / 16 -> q %0d r %0d lat %0d", quotient8, remainder8, lat8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
